// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with 4-word lines.
// Optional hit/miss counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 5,
  parameter int unsigned MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        cache_hit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_wr,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [15:0] mem_data_rd
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 13 - INDEX_BITS;

  typedef enum logic [2:0] {IDLE, WB, RD, WAIT_FILL, DONE} state_t;

  state_t                state;
  logic [1:0]            k;
  logic [15:0]           data_mem [0:LINES*4-1];
  logic [TAG_BITS-1:0]   tag_mem  [0:LINES-1];
  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      dirty;

  logic [15:1]           lat_addr;
  logic [15:0]           lat_data;
  logic                  lat_wr;

  // Offset of each outstanding read, aligned with its return data MEM_LAT cycles later.
  logic [MEM_LAT-1:0]    pipe_v;
  logic [1:0]            pipe_k [0:MEM_LAT-1];

  logic [INDEX_BITS-1:0] req_idx, lidx;
  logic [TAG_BITS-1:0]   req_tag, ltag;
  logic [1:0]            req_off, loff;
  logic                  req, bad, hit, idle_hit, idle_miss;
  logic                  fill_v;
  logic [1:0]            fill_k;

  always_comb begin
    req_idx   = addr[INDEX_BITS+2:3];
    req_tag   = addr[15:INDEX_BITS+3];
    req_off   = addr[2:1];
    lidx      = lat_addr[INDEX_BITS+2:3];
    ltag      = lat_addr[15:INDEX_BITS+3];
    loff      = lat_addr[2:1];
    req       = rd | wr;
    bad       = (rd & wr) | (req & addr[0]);
    hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    idle_hit  = (state == IDLE) && req && !bad && hit;
    idle_miss = (state == IDLE) && req && !bad && !hit;
    fill_v    = pipe_v[MEM_LAT-1];
    fill_k    = pipe_k[MEM_LAT-1];
  end

  always_comb begin
    data_out    = '0;
    done        = 1'b0;
    stall       = 1'b0;
    cache_hit   = 1'b0;
    err         = 1'b0;
    mem_addr    = '0;
    mem_data_wr = '0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    case (state)
      IDLE: begin
        err = bad;
        if (idle_hit) begin
          done      = 1'b1;
          cache_hit = 1'b1;
          data_out  = data_mem[{req_idx, req_off}];
        end
        stall = idle_miss;
      end
      WB: begin
        stall       = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = {tag_mem[lidx], lidx, k, 1'b0};
        mem_data_wr = data_mem[{lidx, k}];
      end
      RD: begin
        stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = {ltag, lidx, k, 1'b0};
      end
      WAIT_FILL: stall = 1'b1;
      DONE: begin
        done     = 1'b1;
        data_out = data_mem[{lidx, loff}];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      valid    <= '0;
      dirty    <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
      pipe_v   <= '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) pipe_k[i] <= '0;
    end else begin
      pipe_v[0] <= (state == RD);
      pipe_k[0] <= k;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_k[i] <= pipe_k[i-1];
      end
      if (fill_v) data_mem[{lidx, fill_k}] <= mem_data_rd;

      case (state)
        IDLE: begin
          if (idle_hit && wr) begin
            data_mem[{req_idx, req_off}] <= data_in;
            dirty[req_idx]               <= 1'b1;
          end
          if (idle_miss) begin
            lat_addr <= addr[15:1];
            lat_data <= data_in;
            lat_wr   <= wr;
            k        <= '0;
            state    <= (valid[req_idx] && dirty[req_idx]) ? WB : RD;
          end
        end
        WB: begin
          k <= k + 2'd1;
          if (k == 2'd3) state <= RD;
        end
        RD: begin
          k <= k + 2'd1;
          if (k == 2'd3) state <= WAIT_FILL;
        end
        WAIT_FILL: begin
          if (fill_v && fill_k == 2'd3) begin
            valid[lidx]   <= 1'b1;
            dirty[lidx]   <= 1'b0;
            tag_mem[lidx] <= ltag;
            state         <= DONE;
          end
        end
        DONE: begin
          if (lat_wr) begin
            data_mem[{lidx, loff}] <= lat_data;
            dirty[lidx]            <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (done) begin
      if (cache_hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (!cache_hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule
